// File: rtl/alu_seq_exec.sv
// alu_seq_exec: sequential ALU execution unit fed by the ALU control decoder.
//
// Accepts {alu_ctl, op_a, op_b} over a valid/ready handshake and returns the
// result over a second valid/ready handshake. Arithmetic and logic ops finish
// one cycle after acceptance; shifts walk one bit position per cycle, so a
// shift by N takes 1+N cycles (N=0 completes like a single-cycle op).
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   request valid
//   in_ready   unit is idle and can accept a request
//   alu_ctl    4-bit operation code (see localparams below)
//   op_a       operand A
//   op_b       operand B; low SHAMT_W bits are the shift amount for shifts
//   out_valid  result valid (held until out_ready)
//   out_ready  consumer accepts the result
//   result     operation result, held from completion to the next completion
//   zero       registered result == 0 flag
//   illegal    alu_ctl of the completed op was not a defined code

module alu_seq_exec #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    // ALU control encodings shared with the control decoder.
    localparam logic [3:0] CtlAnd = 4'b0000;
    localparam logic [3:0] CtlOr  = 4'b0001;
    localparam logic [3:0] CtlAdd = 4'b0010;
    localparam logic [3:0] CtlXor = 4'b0011;
    localparam logic [3:0] CtlSll = 4'b0100;
    localparam logic [3:0] CtlSrl = 4'b0101;
    localparam logic [3:0] CtlSub = 4'b0110;
    localparam logic [3:0] CtlSra = 4'b0111;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    state_e             state_q;
    logic [3:0]         ctl_q;
    logic [WIDTH-1:0]   work_q;
    logic [SHAMT_W-1:0] count_q;
    logic [WIDTH-1:0]   result_q;
    logic               zero_q;
    logic               illegal_q;

    // Decode of the incoming request, used only on the accepting edge.
    logic [WIDTH-1:0]   acc_res;
    logic               acc_is_shift;
    logic               acc_legal;
    logic [SHAMT_W-1:0] acc_shamt;

    // Working register after one more single-bit shift.
    logic [WIDTH-1:0]   shift_next;

    assign acc_shamt = op_b[SHAMT_W-1:0];

    always_comb begin
        acc_res      = '0;
        acc_is_shift = 1'b0;
        acc_legal    = 1'b1;
        case (alu_ctl)
            CtlAdd: acc_res = op_a + op_b;
            CtlSub: acc_res = op_a - op_b;
            CtlAnd: acc_res = op_a & op_b;
            CtlOr:  acc_res = op_a | op_b;
            CtlXor: acc_res = op_a ^ op_b;
            CtlSll, CtlSrl, CtlSra: begin
                // Shift by zero completes immediately with op_a unchanged.
                acc_is_shift = 1'b1;
                acc_res      = op_a;
            end
            default: begin
                acc_legal = 1'b0;
                acc_res   = '0;
            end
        endcase
    end

    always_comb begin
        shift_next = work_q;
        case (ctl_q)
            CtlSll:  shift_next = {work_q[WIDTH-2:0], 1'b0};
            CtlSrl:  shift_next = {1'b0, work_q[WIDTH-1:1]};
            CtlSra:  shift_next = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            default: shift_next = work_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            ctl_q     <= '0;
            work_q    <= '0;
            count_q   <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        ctl_q <= alu_ctl;
                        if (!acc_legal) begin
                            result_q  <= '0;
                            zero_q    <= 1'b1;
                            illegal_q <= 1'b1;
                            state_q   <= StDone;
                        end else if (acc_is_shift && (acc_shamt != '0)) begin
                            work_q  <= op_a;
                            count_q <= acc_shamt;
                            state_q <= StShift;
                        end else begin
                            result_q  <= acc_res;
                            zero_q    <= (acc_res == '0);
                            illegal_q <= 1'b0;
                            state_q   <= StDone;
                        end
                    end
                end

                StShift: begin
                    work_q  <= shift_next;
                    count_q <= count_q - SHAMT_W'(1);
                    // Last step: publish the shifted value directly.
                    if (count_q == SHAMT_W'(1)) begin
                        result_q  <= shift_next;
                        zero_q    <= (shift_next == '0);
                        illegal_q <= 1'b0;
                        state_q   <= StDone;
                    end
                end

                StDone: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle) && !rst;
    assign out_valid = (state_q == StDone);
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
module tb_alu_seq_exec;

    localparam int W = 32;

    localparam logic [3:0] CtlAnd = 4'b0000;
    localparam logic [3:0] CtlOr  = 4'b0001;
    localparam logic [3:0] CtlAdd = 4'b0010;
    localparam logic [3:0] CtlXor = 4'b0011;
    localparam logic [3:0] CtlSll = 4'b0100;
    localparam logic [3:0] CtlSrl = 4'b0101;
    localparam logic [3:0] CtlSub = 4'b0110;
    localparam logic [3:0] CtlSra = 4'b0111;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   alu_ctl;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         illegal;

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    alu_seq_exec #(.WIDTH(W), .SHAMT_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctl   (alu_ctl),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: {illegal, result} straight from the operation definitions.
    function automatic logic [W:0] calc(input logic [3:0] c, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (c)
            CtlAdd:  return {1'b0, a + b};
            CtlSub:  return {1'b0, a - b};
            CtlAnd:  return {1'b0, a & b};
            CtlOr:   return {1'b0, a | b};
            CtlXor:  return {1'b0, a ^ b};
            CtlSll:  return {1'b0, a << sh};
            CtlSrl:  return {1'b0, a >> sh};
            CtlSra:  return {1'b0, W'($signed(a) >>> sh)};
            default: return {1'b1, {W{1'b0}}};
        endcase
    endfunction

    function automatic int extra_cycles(input logic [3:0] c, input logic [W-1:0] b);
        if (c == CtlSll || c == CtlSrl || c == CtlSra) return int'(b[4:0]);
        return 0;
    endfunction

    // Model: 0 = free, 1 = busy for m_wait more cycles, 2 = result pending.
    int           m_phase = 0;
    int           m_wait  = 0;
    logic [W:0]   m_pend;
    logic [W-1:0] m_res   = '0;
    logic         m_zero  = 1'b0;
    logic         m_ill   = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase <= 0;
            m_wait  <= 0;
            m_res   <= '0;
            m_zero  <= 1'b0;
            m_ill   <= 1'b0;
        end else if (m_phase == 0) begin
            if (in_valid) begin
                if (extra_cycles(alu_ctl, op_b) > 0) begin
                    m_phase <= 1;
                    m_wait  <= extra_cycles(alu_ctl, op_b);
                    m_pend  <= calc(alu_ctl, op_a, op_b);
                end else begin
                    m_phase <= 2;
                    m_res   <= calc(alu_ctl, op_a, op_b) & {1'b0, {W{1'b1}}};
                    m_ill   <= calc(alu_ctl, op_a, op_b) >> W;
                    m_zero  <= (calc(alu_ctl, op_a, op_b) & {1'b0, {W{1'b1}}}) == 0;
                end
            end
        end else if (m_phase == 1) begin
            if (m_wait == 1) begin
                m_phase <= 2;
                m_res   <= m_pend[W-1:0];
                m_ill   <= m_pend[W];
                m_zero  <= (m_pend[W-1:0] == '0);
            end
            m_wait <= m_wait - 1;
        end else if (out_ready) begin
            m_phase <= 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            #1;
            check("cyc_in_ready", W'(in_ready), W'((m_phase == 0) && !rst));
            check("cyc_out_valid", W'(out_valid), W'(m_phase == 2));
            check("cyc_result", result, m_res);
            check("cyc_zero", W'(zero), W'(m_zero));
            check("cyc_illegal", W'(illegal), W'(m_ill));
        end
    end

    task automatic wait_idle();
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("wait_idle", W'(in_ready), W'(1));
    endtask

    task automatic run_op(input string name, input logic [3:0] c, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_res,
                          input logic exp_ill, input int exp_lat);
        int lat;
        wait_idle();
        alu_ctl  = c;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_latency"}, W'(lat), W'(exp_lat));
        check({name, "_result"}, result, exp_res);
        check({name, "_zero"}, W'(zero), W'(exp_res == '0));
        check({name, "_illegal"}, W'(illegal), W'(exp_ill));
        @(negedge clk);
        check({name, "_ready_back"}, W'(in_ready), W'(1));
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        alu_ctl   = '0;
        op_a      = '0;
        op_b      = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        #1;
        check("reset_in_ready", W'(in_ready), W'(1));
        check("reset_out_valid", W'(out_valid), W'(0));
        check("reset_result", result, W'(0));
        check("reset_zero", W'(zero), W'(0));
        check("reset_illegal", W'(illegal), W'(0));

        run_op("add_wrap", CtlAdd, 32'h0000_0005, 32'hFFFF_FFFB, 32'h0000_0000, 1'b0, 1);
        run_op("sra4", CtlSra, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 5);
        run_op("srl4", CtlSrl, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 5);
        run_op("sll31", CtlSll, 32'h0000_0001, 32'h0000_003F, 32'h8000_0000, 1'b0, 32);
        run_op("sll0", CtlSll, 32'h0000_0001, 32'h0000_0020, 32'h0000_0001, 1'b0, 1);

        // Stalled consumer with a competing request held on the input.
        wait_idle();
        alu_ctl   = CtlSub;
        op_a      = 32'd3;
        op_b      = 32'd5;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        alu_ctl = CtlAdd;
        op_a    = 32'd7;
        op_b    = 32'd7;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("stall_out_valid", W'(out_valid), W'(1));
            check("stall_result", result, 32'hFFFF_FFFE);
            check("stall_in_ready", W'(in_ready), W'(0));
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        check("release_out_valid", W'(out_valid), W'(0));
        check("release_in_ready", W'(in_ready), W'(1));
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("queued_out_valid", W'(out_valid), W'(1));
        check("queued_result", result, 32'd14);

        run_op("illegal", 4'b1011, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1'b1, 1);
        run_op("xor", CtlXor, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0, 1'b0, 1);

        // Reset mid-shift discards the operation.
        wait_idle();
        alu_ctl  = CtlSll;
        op_a     = 32'd1;
        op_b     = 32'd20;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_out_valid", W'(out_valid), W'(0));
        check("midrst_result", result, W'(0));
        check("midrst_zero", W'(zero), W'(0));
        check("midrst_in_ready", W'(in_ready), W'(1));
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            #1;
            check("midrst_no_pulse", W'(out_valid), W'(0));
        end
        run_op("add_after_rst", CtlAdd, 32'd2, 32'd2, 32'd4, 1'b0, 1);

        // Randomized traffic; the per-cycle model comparison does the checking.
        for (int i = 0; i < 4000; i++) begin
            int r;
            @(negedge clk);
            rst      = ($urandom_range(0, 299) == 0);
            in_valid = $urandom_range(0, 1) == 1;
            r = $urandom_range(0, 8);
            case (r)
                0: alu_ctl = CtlAnd;
                1: alu_ctl = CtlOr;
                2: alu_ctl = CtlAdd;
                3: alu_ctl = CtlXor;
                4: alu_ctl = CtlSll;
                5: alu_ctl = CtlSrl;
                6: alu_ctl = CtlSub;
                7: alu_ctl = CtlSra;
                default: alu_ctl = {1'b1, 3'($urandom_range(0, 7))};
            endcase
            op_a = $urandom;
            op_b = ($urandom_range(0, 1) == 1) ? $urandom : W'($urandom_range(0, 40));
            out_ready = $urandom_range(0, 3) != 0;
        end
        @(negedge clk);
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (40) @(negedge clk);
        chk_en = 1'b0;
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
